// File: rtl/sb_pattern_gen_param.sv
// sb_pattern_gen_param
// Sideband initialisation pattern generator for the UCIe sideband TX path.
// Streams DATA_W-bit pattern words (clock, PRBS or fixed) to the sideband
// serializer until the RX side detects the partner pattern. It then sends
// POST_DETECT_ITER extra words and reports done to the LTSM. A cycle-count
// timeout covers the SEND and POST phases.
//
// Build option: define SB_PATTERN_PRBS_EN to build the PRBS23 word source.
// Without it, i_mode=01 produces the clock pattern and PRBS_SEED is unused.
//
// Serializer handshake: o_pattern is valid for the serializer while
// o_pattern_valid=1. i_ser_done is a one-cycle pulse meaning the current word
// has been consumed. The next word is registered on the edge that samples
// i_ser_done, so o_pattern holds steady between handshakes. i_ser_done is
// ignored while o_pattern_valid=0.
//
// dbg_state exposes the FSM encoding for checkers:
// 0 IDLE, 1 SEND, 2 POST, 3 DONE, 4 TOUT.
module sb_pattern_gen_param #(
  parameter int          DATA_W           = 64,
  parameter int          TIMEOUT_CYC      = 800000,
  parameter int          POST_DETECT_ITER = 4,
  parameter logic [22:0] PRBS_SEED        = 23'h7FFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start_pattern_req,
  input  logic              i_rx_sb_pattern_samp_done,
  input  logic              i_ser_done,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_fixed_pattern,
  output logic [DATA_W-1:0] o_pattern,
  output logic              o_pattern_valid,
  output logic              o_start_pattern_done,
  output logic              o_pattern_time_out,
  output logic [2:0]        dbg_state
);

  localparam int TO_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int IT_W = (POST_DETECT_ITER < 1) ? 1 : $clog2(POST_DETECT_ITER + 1);

  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);
  localparam logic [IT_W-1:0] IT_INIT = IT_W'(POST_DETECT_ITER);
  localparam logic [IT_W-1:0] IT_ONE  = IT_W'(1);

  // Alternating 0/1 word with bit 0 = 0 (0xAAAA... for even widths).
  function automatic logic [DATA_W-1:0] clock_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w[i] = 1'((i % 2) == 1);
    end
    return w;
  endfunction

  localparam logic [DATA_W-1:0] CLK_WORD = clock_word();

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_POST = 3'd2,
    S_DONE = 3'd3,
    S_TOUT = 3'd4
  } state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic              det_q;
  logic [IT_W-1:0]   iter_q;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_inc;
  logic              to_expire;
  logic [1:0]        load_mode;
  logic [DATA_W-1:0] next_word;

  assign dbg_state = state;

  // The timeout counter saturates at TIMEOUT_CYC. Expiry is the cycle whose
  // increment reaches it, so TOUT is entered exactly TIMEOUT_CYC edges after
  // SEND entry.
  assign to_inc    = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1);
  assign to_expire = (to_inc == TO_MAX);

  // In IDLE the mode comes straight from the input, because the first word
  // loads on the same edge that latches it. Later words use the latched mode.
  assign load_mode = (state == S_IDLE) ? i_mode : mode_q;

`ifdef SB_PATTERN_PRBS_EN
  logic [22:0]       lfsr_q;
  logic [22:0]       lfsr_base;
  logic [22:0]       lfsr_next;
  logic [DATA_W-1:0] prbs_word;
  logic              load;

  // Fibonacci x^23+x^18+1. The output bit is the oldest register bit [22],
  // and the feedback [22]^[17] shifts in at bit 0. Word bit k is the k-th
  // output bit, so bit 0 goes out first.
  function automatic logic [DATA_W+22:0] prbs_advance(input logic [22:0] start);
    logic [22:0]       s;
    logic [DATA_W-1:0] w;
    s = start;
    w = '0;
    for (int k = 0; k < DATA_W; k++) begin
      w[k] = s[22];
      s    = {s[21:0], s[22] ^ s[17]};
    end
    return {s, w};
  endfunction

  // A new request always restarts the sequence from the seed.
  assign lfsr_base = (state == S_IDLE) ? PRBS_SEED : lfsr_q;
  assign {lfsr_next, prbs_word} = prbs_advance(lfsr_base);
  assign load = i_start_pattern_req &&
                ((state == S_IDLE) ||
                 (((state == S_SEND) || (state == S_POST)) && i_ser_done));

  // LFSR state advances DATA_W steps on every word load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= PRBS_SEED;
    end else if (load) begin
      lfsr_q <= lfsr_next;
    end
  end
`else
  logic unused_prbs_seed;
  assign unused_prbs_seed = ^PRBS_SEED;
`endif

  // Word source selection. Mode 11, and mode 01 without the PRBS build,
  // fall back to the clock pattern.
  always_comb begin
    next_word = CLK_WORD;
    case (load_mode)
      2'b10:   next_word = i_fixed_pattern;
`ifdef SB_PATTERN_PRBS_EN
      2'b01:   next_word = prbs_word;
`endif
      default: next_word = CLK_WORD;
    endcase
  end

  // Sequencing FSM with registered outputs. Dropping the request returns to
  // IDLE from any state and clears all status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                <= S_IDLE;
      mode_q               <= 2'b00;
      det_q                <= 1'b0;
      iter_q               <= '0;
      to_cnt               <= '0;
      o_pattern            <= '0;
      o_pattern_valid      <= 1'b0;
      o_start_pattern_done <= 1'b0;
      o_pattern_time_out   <= 1'b0;
    end else if (!i_start_pattern_req) begin
      state                <= S_IDLE;
      det_q                <= 1'b0;
      iter_q               <= '0;
      to_cnt               <= '0;
      o_pattern            <= '0;
      o_pattern_valid      <= 1'b0;
      o_start_pattern_done <= 1'b0;
      o_pattern_time_out   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state           <= S_SEND;
          mode_q          <= i_mode;
          o_pattern       <= next_word;
          o_pattern_valid <= 1'b1;
          det_q           <= 1'b0;
          iter_q          <= '0;
          to_cnt          <= '0;
        end
        S_SEND: begin
          to_cnt <= to_inc;
          if (i_ser_done) begin
            o_pattern <= next_word;
          end
          // A handshake in the detect cycle belongs to SEND and does not
          // count toward the post-detect iterations.
          if (i_rx_sb_pattern_samp_done || det_q) begin
            det_q <= 1'b1;
            if (POST_DETECT_ITER == 0) begin
              state                <= S_DONE;
              o_pattern_valid      <= 1'b0;
              o_start_pattern_done <= 1'b1;
            end else begin
              state  <= S_POST;
              iter_q <= IT_INIT;
            end
          end else if (to_expire) begin
            state              <= S_TOUT;
            o_pattern_valid    <= 1'b0;
            o_pattern_time_out <= 1'b1;
          end
        end
        S_POST: begin
          to_cnt <= to_inc;
          if (i_ser_done) begin
            o_pattern <= next_word;
            iter_q    <= iter_q - IT_ONE;
          end
          // Completion takes priority over a timeout expiring in the same cycle.
          if (i_ser_done && (iter_q == IT_ONE)) begin
            state                <= S_DONE;
            o_pattern_valid      <= 1'b0;
            o_start_pattern_done <= 1'b1;
          end else if (to_expire) begin
            state              <= S_TOUT;
            o_pattern_valid    <= 1'b0;
            o_pattern_time_out <= 1'b1;
          end
        end
        S_DONE, S_TOUT: begin
          state <= state;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_pattern_gen_param.sv
// tb_sb_pattern_gen_param
// Directed bench for sb_pattern_gen_param with DATA_W=64 and TIMEOUT_CYC=100.
// Instance dut uses POST_DETECT_ITER=4 and instance dut0 uses POST_DETECT_ITER=0.
// Expected PRBS words depend on whether SB_PATTERN_PRBS_EN is defined.
module tb_sb_pattern_gen_param;

  localparam int          W       = 64;
  localparam logic [W-1:0] CLK_PAT = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [22:0] SEED    = 23'h7FFFFF;
`ifdef SB_PATTERN_PRBS_EN
  // First PRBS word from the all-ones seed, worked out by hand from the
  // recurrence b[n] = b[n-23] ^ b[n-18].
  localparam logic [W-1:0] PRBS_W0 = 64'hF800_3E00_007F_FFFF;
`endif

  // clock / reset
  logic i_clk = 1'b0;
  logic rst_n;
  always #5 i_clk = ~i_clk;

  // dut (POST_DETECT_ITER=4)
  logic         req, samp, ser;
  logic [1:0]   mode;
  logic [W-1:0] fixed;
  logic [W-1:0] pattern;
  logic         valid, done, tout;
  logic [2:0]   dbg;

  // dut0 (POST_DETECT_ITER=0)
  logic         req0, samp0, ser0;
  logic [1:0]   mode0;
  logic [W-1:0] fixed0;
  logic [W-1:0] pattern0;
  logic         valid0, done0, tout0;
  logic [2:0]   dbg0;

  sb_pattern_gen_param #(
    .DATA_W(W), .TIMEOUT_CYC(100), .POST_DETECT_ITER(4), .PRBS_SEED(SEED)
  ) dut (
    .i_clk                     (i_clk),
    .i_rst_n                   (rst_n),
    .i_start_pattern_req       (req),
    .i_rx_sb_pattern_samp_done (samp),
    .i_ser_done                (ser),
    .i_mode                    (mode),
    .i_fixed_pattern           (fixed),
    .o_pattern                 (pattern),
    .o_pattern_valid           (valid),
    .o_start_pattern_done      (done),
    .o_pattern_time_out        (tout),
    .dbg_state                 (dbg)
  );

  sb_pattern_gen_param #(
    .DATA_W(W), .TIMEOUT_CYC(100), .POST_DETECT_ITER(0), .PRBS_SEED(SEED)
  ) dut0 (
    .i_clk                     (i_clk),
    .i_rst_n                   (rst_n),
    .i_start_pattern_req       (req0),
    .i_rx_sb_pattern_samp_done (samp0),
    .i_ser_done                (ser0),
    .i_mode                    (mode0),
    .i_fixed_pattern           (fixed0),
    .o_pattern                 (pattern0),
    .o_pattern_valid           (valid0),
    .o_start_pattern_done      (done0),
    .o_pattern_time_out        (tout0),
    .dbg_state                 (dbg0)
  );

  // scoreboard
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef SB_PATTERN_PRBS_EN
  // Reference bit-stream model: b[0..22] holds the seed with its MSB first,
  // and b[n] = b[n-23] ^ b[n-18]. Word w holds bits b[64w .. 64w+63].
  function automatic logic [W-1:0] prbs_ref(input int w);
    logic         b [0:W*8+22];
    logic [22:0]  seed_v;
    logic [W-1:0] r;
    seed_v = SEED;
    for (int k = 0; k < 23; k++) b[k] = seed_v[22-k];
    for (int n = 23; n <= W*(w+1); n++) b[n] = b[n-23] ^ b[n-18];
    for (int k = 0; k < W; k++) r[k] = b[W*w+k];
    return r;
  endfunction
`endif

  function automatic logic [W-1:0] exp_word(input int w);
`ifdef SB_PATTERN_PRBS_EN
    return prbs_ref(w);
`else
    return (w >= 0) ? CLK_PAT : '0;
`endif
  endfunction

  // driver: hold ser/samp for one cycle. Inputs change and outputs are
  // sampled 1 time unit after the rising edge.
  task automatic tick(input logic ser_v, input logic samp_v);
    ser  = ser_v;
    samp = samp_v;
    @(posedge i_clk);
    #1;
    ser  = 1'b0;
    samp = 1'b0;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  int   post_cnt;
  int   first;
  logic got_done;
  logic s_v, d_v;

  initial begin
    rst_n = 1'b0;
    req = 1'b0; samp = 1'b0; ser = 1'b0; mode = 2'b00; fixed = '0;
    req0 = 1'b0; samp0 = 1'b0; ser0 = 1'b0; mode0 = 2'b00; fixed0 = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid",   W'(valid),   W'(0));
    check("rst_pattern", pattern,     W'(0));
    check("rst_done",    W'(done),    W'(0));
    check("rst_tout",    W'(tout),    W'(0));
    check("rst_state",   W'(dbg),     W'(0));
    rst_n = 1'b1;
    tick(1'b0, 1'b0);

    // clock mode happy path
    mode = 2'b00; req = 1'b1;
    tick(1'b0, 1'b0);
    check("clk_valid", W'(valid), W'(1));
    check("clk_word0", pattern, CLK_PAT);
    mode = 2'b10; fixed = 64'h1234;   // must not take effect before next request
    post_cnt = 0; got_done = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      s_v = valid && ((c % 8) == 7);
      d_v = (c == 20);
      if (s_v && c > 20) post_cnt++;
      tick(s_v, d_v);
      if (done) got_done = 1'b1;
      else if (s_v) check("clk_word", pattern, CLK_PAT);
    end
    check("clk_done",       W'(done),     W'(1));
    check("clk_post_words", W'(post_cnt), W'(4));
    check("clk_done_valid", W'(valid),    W'(0));
    check("clk_done_tout",  W'(tout),     W'(0));
    tick(1'b0, 1'b0);
    check("clk_done_held",  W'(done),     W'(1));
    req = 1'b0;
    tick(1'b0, 1'b0);
    check("clk_drop_done",  W'(done),     W'(0));
    check("clk_drop_state", W'(dbg),      W'(0));

    // timeout: TOUT exactly 100 cycles after SEND entry
    mode = 2'b00; req = 1'b1;
    tick(1'b0, 1'b0);
    first = 0;
    for (int k = 1; k <= 150 && first == 0; k++) begin
      tick(1'b0, 1'b0);
      if (tout) first = k;
    end
    check("tout_cycle", W'(first), W'(100));
    check("tout_valid", W'(valid), W'(0));
    check("tout_done",  W'(done),  W'(0));
    tick(1'b0, 1'b0);
    check("tout_held",  W'(tout),  W'(1));
    req = 1'b0;
    tick(1'b0, 1'b0);
    check("tout_clear", W'(tout),  W'(0));
    check("tout_clr_valid", W'(valid), W'(0));

    // PRBS words (clock pattern when PRBS is not built)
`ifdef SB_PATTERN_PRBS_EN
    exp_q.push_back(PRBS_W0);
`else
    exp_q.push_back(CLK_PAT);
`endif
    for (int w = 1; w < 3; w++) exp_q.push_back(exp_word(w));
    exp_q.push_back(exp_word(2));
    mode = 2'b01; req = 1'b1;
    tick(1'b0, 1'b0);
    check("prbs_w0", pattern, exp_q.pop_front());
    tick(1'b1, 1'b0);
    check("prbs_w1", pattern, exp_q.pop_front());
    tick(1'b1, 1'b0);
    check("prbs_w2", pattern, exp_q.pop_front());
    tick(1'b0, 1'b0);
    check("prbs_hold", pattern, exp_q.pop_front());
    req = 1'b0;
    tick(1'b0, 1'b0);

    // abort in POST with two iterations left, then restart
    mode = 2'b01; req = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    check("abort_in_post", W'(dbg), W'(2));
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("abort_pre_valid", W'(valid), W'(1));
    check("abort_pre_done",  W'(done),  W'(0));
    req = 1'b0;
    tick(1'b0, 1'b0);
    check("abort_valid",   W'(valid), W'(0));
    check("abort_pattern", pattern,   W'(0));
    check("abort_state",   W'(dbg),   W'(0));
    req = 1'b1;
    tick(1'b0, 1'b0);
    check("restart_valid", W'(valid), W'(1));
    check("restart_w0",    pattern,   exp_word(0));
    repeat (5) tick(1'b1, 1'b0);
    check("restart_send",  W'(dbg),   W'(1));
    check("restart_w5",    pattern,   exp_word(5));
    check("restart_nodone", W'(done), W'(0));
    tick(1'b0, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    check("restart_done",  W'(done),  W'(1));
    req = 1'b0;
    tick(1'b0, 1'b0);

    // samp_done together with ser_done: still four more words
    mode = 2'b00; req = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    check("simul_3_done",  W'(done),  W'(0));
    check("simul_3_valid", W'(valid), W'(1));
    tick(1'b1, 1'b0);
    check("simul_4_done",  W'(done),  W'(1));
    req = 1'b0;
    tick(1'b0, 1'b0);

    // final ser_done in the timeout-expiry cycle: done wins
    mode = 2'b00; req = 1'b1;
    tick(1'b0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      tick((c == 84) || (c == 88) || (c == 92) || (c == 99), c == 0);
    end
    check("race_done",  W'(done),  W'(1));
    check("race_tout",  W'(tout),  W'(0));
    check("race_valid", W'(valid), W'(0));
    req = 1'b0;
    tick(1'b0, 1'b0);

    // one word short at expiry: timeout
    mode = 2'b00; req = 1'b1;
    tick(1'b0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      tick((c == 84) || (c == 88) || (c == 92), c == 0);
    end
    check("short_tout", W'(tout), W'(1));
    check("short_done", W'(done), W'(0));
    req = 1'b0;
    tick(1'b0, 1'b0);

    // mode 11 behaves as clock
    mode = 2'b11; req = 1'b1;
    tick(1'b0, 1'b0);
    check("mode3_w0", pattern, CLK_PAT);
    tick(1'b1, 1'b0);
    check("mode3_w1", pattern, CLK_PAT);
    req = 1'b0;
    tick(1'b0, 1'b0);

    // fixed mode with POST_DETECT_ITER=0
    mode0 = 2'b10; fixed0 = 64'h0123_4567_89AB_CDEF; req0 = 1'b1;
    tick(1'b0, 1'b0);
    check("fix_valid", W'(valid0), W'(1));
    check("fix_w0",    pattern0,   64'h0123_4567_89AB_CDEF);
    fixed0 = 64'hFEDC_BA98_7654_3210;
    tick(1'b0, 1'b0);
    check("fix_hold",  pattern0,   64'h0123_4567_89AB_CDEF);
    ser0 = 1'b1;
    tick(1'b0, 1'b0);
    ser0 = 1'b0;
    check("fix_w1",    pattern0,   64'hFEDC_BA98_7654_3210);
    samp0 = 1'b1;
    tick(1'b0, 1'b0);
    samp0 = 1'b0;
    check("fix_done",       W'(done0),  W'(1));
    check("fix_done_valid", W'(valid0), W'(0));
    check("fix_done_state", W'(dbg0),   W'(3));
    req0 = 1'b0;
    tick(1'b0, 1'b0);
    check("fix_drop_done",  W'(done0),  W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
